pong_game_controller: RTL and testbench
=======================================

Name: pong_game_controller

Overview:
Per-frame game sequencer that owns all object positions fed to the VGA graphics driver: paddle 1/2 Y, ball X/Y, plus scores. It advances game state once per frame on frame_tick, applying button-driven paddle motion, ball motion, wall and paddle bounces, and scoring. A four-state FSM handles serve, play, point hold and game over.

Parameters:
HEIGHT_COUNTER_SIZE, 9, Y position ports are [HEIGHT_COUNTER_SIZE:0]
WIDTH_COUNTER_SIZE, 9, X position ports are [WIDTH_COUNTER_SIZE:0]
SCREEN_WIDTH, 640, active pixels per line
SCREEN_HEIGHT, 480, active lines
PADDLE_1_X / PADDLE_2_X, 16 / 616, fixed left edge of each paddle
PADDLE_WIDTH / PADDLE_HEIGHT, 8 / 64, paddle size in pixels
BALL_SIDE_SIZE, 8, ball square side
INITIAL_PADDLE_Y / INITIAL_BALL_X / INITIAL_BALL_Y, 208 / 316 / 236, home positions
PADDLE_SPEED / BALL_SPEED, 4 / 2, pixels per frame (each axis for the ball)
SCORE_WIDTH / MAX_SCORE, 4 / 9, score width and winning score
SCORE_HOLD_FRAMES, 60, frames frozen after a point

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse, once per frame, during vertical blanking
p1_up, p1_down, p2_up, p2_down  in  1 each  synchronized button levels, active-high
serve  in  1  synchronized serve/restart button level
paddle_1_pos, paddle_2_pos  out  HEIGHT_COUNTER_SIZE+1  paddle top Y
ball_pos_x  out  WIDTH_COUNTER_SIZE+1  ball left X
ball_pos_y  out  HEIGHT_COUNTER_SIZE+1  ball top Y
score_1, score_2  out  SCORE_WIDTH  points
game_state  out  2  IDLE=0, PLAY=1, SCORED=2, GAME_OVER=3

Behaviour:
- Reset (async, active-low): paddles=INITIAL_PADDLE_Y, ball=(INITIAL_BALL_X, INITIAL_BALL_Y), scores=0, state=IDLE, dir_x=right, dir_y=down, hold counter=0, serve edge register=0. All outputs are registered.
- serve is rising-edge detected internally. A held level never retriggers.
- All updates occur on the edge where frame_tick=1. Outputs change one cycle later. No state changes without frame_tick, except a serve edge.
- Paddles move in IDLE, PLAY and SCORED, and are frozen in GAME_OVER. up only: pos-PADDLE_SPEED, saturating at 0. down only: pos+PADDLE_SPEED, saturating at SCREEN_HEIGHT-PADDLE_HEIGHT (416). Both or neither pressed: no move.
- Ball logic uses the pre-update paddle positions. All arithmetic is done one bit wider than the port to avoid wrap.
- IDLE: ball at home position. Serve edge -> PLAY. The ball does not move on the transition cycle even if frame_tick is coincident.
- PLAY, Y axis:
  - Candidate ny = y ± BALL_SPEED.
  - Moving down and ny >= SCREEN_HEIGHT-BALL_SIDE_SIZE: clamp to 472, flip dir_y.
  - Moving up and y < BALL_SPEED: clamp to 0, flip dir_y.
- PLAY, X axis, moving left:
  - Paddle 1 hit when x >= P1F and nx <= P1F (P1F = PADDLE_1_X+PADDLE_WIDTH), and the ball and paddle Y ranges overlap (y+BALL_SIDE_SIZE > p1 and y < p1+PADDLE_HEIGHT). On hit: x=P1F, flip dir_x.
  - Otherwise, if x < BALL_SPEED: point to player 2.
- PLAY, X axis, moving right:
  - Paddle 2 hit when x+BALL_SIDE_SIZE <= PADDLE_2_X and nx+BALL_SIDE_SIZE >= PADDLE_2_X, with Y overlap. On hit: x=PADDLE_2_X-BALL_SIDE_SIZE, flip dir_x.
  - Otherwise, if nx > SCREEN_WIDTH-BALL_SIDE_SIZE: point to player 1.
- Point scoring:
  - Scorer's score increments.
  - Ball goes to home position; dir_x points toward the conceding player; dir_y=down; hold counter cleared.
  - If the new score == MAX_SCORE -> GAME_OVER, otherwise -> SCORED.
  - A Y bounce in the same frame is discarded.
- SCORED: the ball holds. The hold counter increments per frame_tick. The tick that brings it to SCORE_HOLD_FRAMES -> PLAY (auto-serve). Ball motion resumes on the next tick.
- GAME_OVER: everything holds. A serve edge clears scores, homes the ball and paddles, sets dir_x=right and dir_y=down, and goes to IDLE.
- Serve edges are ignored in PLAY and SCORED.
- Reset asserted mid-frame or mid-hold returns everything to reset values immediately.

Test Plan:
- Reset values: assert then release rst -> outputs 208/208/316/236, scores 0/0, game_state=0. With no serve, 200 ticks -> the ball never moves.
- Paddle saturation: hold p1_up for 60 ticks -> paddle_1_pos reaches 0 at tick 52 and stays 0. Hold p2_down for 60 ticks -> 416 at tick 52, stays. Both p1 buttons pressed -> no change.
- Wall bounce: serve, then ticks -> ball_y reaches 472 at tick 118 and reads 470 at tick 119. ball_x = 316+2n throughout.
- Paddle hit: serve, hold p2_down for 52 ticks (p2=416). At tick 146, ball (608,416) -> dir_x left. Tick 147 -> x=606.
- Miss and hold: serve with no buttons pressed. At tick 159, score_1=1, game_state=2, ball=(316,236). After 60 more ticks, game_state=1 and the ball moves right.
- Game over: repeat misses until score_1=9 -> game_state=3, outputs frozen across ticks. Holding serve high gives exactly one restart -> scores 0, state 0.

Source files
------------

// File: rtl/pong_game_controller.sv
// Per-frame pong sequencer: paddle motion, ball motion and bounces, scoring,
// and the serve / play / point-hold / game-over state machine.
module pong_game_controller #(
    parameter int HEIGHT_COUNTER_SIZE = 9,
    parameter int WIDTH_COUNTER_SIZE  = 9,
    parameter int SCREEN_WIDTH        = 640,
    parameter int SCREEN_HEIGHT       = 480,
    parameter int PADDLE_1_X          = 16,
    parameter int PADDLE_2_X          = 616,
    parameter int PADDLE_WIDTH        = 8,
    parameter int PADDLE_HEIGHT       = 64,
    parameter int BALL_SIDE_SIZE      = 8,
    parameter int INITIAL_PADDLE_Y    = 208,
    parameter int INITIAL_BALL_X      = 316,
    parameter int INITIAL_BALL_Y      = 236,
    parameter int PADDLE_SPEED        = 4,
    parameter int BALL_SPEED          = 2,
    parameter int SCORE_WIDTH         = 4,
    parameter int MAX_SCORE           = 9,
    parameter int SCORE_HOLD_FRAMES   = 60
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          p1_up,
    input  logic                          p1_down,
    input  logic                          p2_up,
    input  logic                          p2_down,
    input  logic                          serve,
    output logic [HEIGHT_COUNTER_SIZE:0]  paddle_1_pos,
    output logic [HEIGHT_COUNTER_SIZE:0]  paddle_2_pos,
    output logic [WIDTH_COUNTER_SIZE:0]   ball_pos_x,
    output logic [HEIGHT_COUNTER_SIZE:0]  ball_pos_y,
    output logic [SCORE_WIDTH-1:0]        score_1,
    output logic [SCORE_WIDTH-1:0]        score_2,
    output logic [1:0]                    game_state
);

    localparam int HOLD_W = $clog2(SCORE_HOLD_FRAMES + 1);

    typedef logic [HEIGHT_COUNTER_SIZE:0]   ypos_t;
    typedef logic [WIDTH_COUNTER_SIZE:0]    xpos_t;
    typedef logic [HEIGHT_COUNTER_SIZE+1:0] yext_t;
    typedef logic [WIDTH_COUNTER_SIZE+1:0]  xext_t;
    typedef logic [SCORE_WIDTH-1:0]         score_t;
    typedef logic [HOLD_W-1:0]              hold_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_SCORED    = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    localparam ypos_t  PADDLE_HOME   = ypos_t'(INITIAL_PADDLE_Y);
    localparam xpos_t  BALL_HOME_X   = xpos_t'(INITIAL_BALL_X);
    localparam ypos_t  BALL_HOME_Y   = ypos_t'(INITIAL_BALL_Y);
    localparam yext_t  PADDLE_MAX_Y  = yext_t'(SCREEN_HEIGHT - PADDLE_HEIGHT);
    localparam yext_t  PADDLE_STEP   = yext_t'(PADDLE_SPEED);
    localparam yext_t  PADDLE_H_Y    = yext_t'(PADDLE_HEIGHT);
    localparam yext_t  BALL_SIZE_Y   = yext_t'(BALL_SIDE_SIZE);
    localparam yext_t  BALL_STEP_Y   = yext_t'(BALL_SPEED);
    localparam yext_t  BALL_MAX_Y    = yext_t'(SCREEN_HEIGHT - BALL_SIDE_SIZE);
    localparam xext_t  BALL_SIZE_X   = xext_t'(BALL_SIDE_SIZE);
    localparam xext_t  BALL_STEP_X   = xext_t'(BALL_SPEED);
    localparam xext_t  BALL_MAX_X    = xext_t'(SCREEN_WIDTH - BALL_SIDE_SIZE);
    localparam xext_t  P1_FACE_X     = xext_t'(PADDLE_1_X + PADDLE_WIDTH);
    localparam xext_t  P2_FACE_X     = xext_t'(PADDLE_2_X);
    localparam xpos_t  P1_STOP_X     = xpos_t'(PADDLE_1_X + PADDLE_WIDTH);
    localparam xpos_t  P2_STOP_X     = xpos_t'(PADDLE_2_X - BALL_SIDE_SIZE);
    localparam ypos_t  BALL_CLAMP_Y  = ypos_t'(SCREEN_HEIGHT - BALL_SIDE_SIZE);
    localparam score_t SCORE_WIN     = score_t'(MAX_SCORE);
    localparam hold_t  HOLD_LAST     = hold_t'(SCORE_HOLD_FRAMES);

    state_t state_q, state_n;
    ypos_t  p1_q, p1_n, p2_q, p2_n;
    xpos_t  bx_q, bx_n;
    ypos_t  by_q, by_n;
    logic   dx_q, dx_n;   // 1 = moving right
    logic   dy_q, dy_n;   // 1 = moving down
    hold_t  hold_q, hold_n;
    score_t s1_q, s1_n, s2_q, s2_n;
    logic   serve_q;
    logic   serve_edge;

    yext_t  by_e, ny_e;
    xext_t  bx_e, nx_e;
    logic   hit_1, hit_2, point_1, point_2;

    function automatic ypos_t paddle_step(input ypos_t pos, input logic up, input logic dn);
        yext_t p;
        p = {1'b0, pos};
        if (up && !dn) begin
            if (p < PADDLE_STEP) p = '0;
            else                 p = p - PADDLE_STEP;
        end else if (dn && !up) begin
            p = p + PADDLE_STEP;
            if (p > PADDLE_MAX_Y) p = PADDLE_MAX_Y;
        end
        return p[HEIGHT_COUNTER_SIZE:0];
    endfunction

    function automatic logic y_overlap(input ypos_t ball_y, input ypos_t pad_y);
        yext_t b;
        yext_t p;
        b = {1'b0, ball_y};
        p = {1'b0, pad_y};
        return ((b + BALL_SIZE_Y) > p) && (b < (p + PADDLE_H_Y));
    endfunction

    assign serve_edge = serve & ~serve_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            p1_q    <= PADDLE_HOME;
            p2_q    <= PADDLE_HOME;
            bx_q    <= BALL_HOME_X;
            by_q    <= BALL_HOME_Y;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            hold_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            serve_q <= 1'b0;
        end else begin
            state_q <= state_n;
            p1_q    <= p1_n;
            p2_q    <= p2_n;
            bx_q    <= bx_n;
            by_q    <= by_n;
            dx_q    <= dx_n;
            dy_q    <= dy_n;
            hold_q  <= hold_n;
            s1_q    <= s1_n;
            s2_q    <= s2_n;
            serve_q <= serve;
        end
    end

    // Ball candidates and collision tests use the pre-update paddle positions.
    always_comb begin
        by_e    = {1'b0, by_q};
        bx_e    = {1'b0, bx_q};
        ny_e    = dy_q ? (by_e + BALL_STEP_Y) : (by_e - BALL_STEP_Y);
        nx_e    = dx_q ? (bx_e + BALL_STEP_X) : (bx_e - BALL_STEP_X);
        hit_1   = !dx_q && (bx_e >= P1_FACE_X) && (nx_e <= P1_FACE_X) && y_overlap(by_q, p1_q);
        hit_2   = dx_q && ((bx_e + BALL_SIZE_X) <= P2_FACE_X) &&
                  ((nx_e + BALL_SIZE_X) >= P2_FACE_X) && y_overlap(by_q, p2_q);
        point_2 = !dx_q && !hit_1 && (bx_e < BALL_STEP_X);
        point_1 = dx_q && !hit_2 && (nx_e > BALL_MAX_X);
    end

    always_comb begin
        state_n = state_q;
        p1_n    = p1_q;
        p2_n    = p2_q;
        bx_n    = bx_q;
        by_n    = by_q;
        dx_n    = dx_q;
        dy_n    = dy_q;
        hold_n  = hold_q;
        s1_n    = s1_q;
        s2_n    = s2_q;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    p1_n = paddle_step(p1_q, p1_up, p1_down);
                    p2_n = paddle_step(p2_q, p2_up, p2_down);
                end
                bx_n = BALL_HOME_X;
                by_n = BALL_HOME_Y;
                if (serve_edge) state_n = S_PLAY;
            end

            S_PLAY: begin
                if (frame_tick) begin
                    p1_n = paddle_step(p1_q, p1_up, p1_down);
                    p2_n = paddle_step(p2_q, p2_up, p2_down);

                    if (dy_q) begin
                        if (ny_e >= BALL_MAX_Y) begin
                            by_n = BALL_CLAMP_Y;
                            dy_n = 1'b0;
                        end else begin
                            by_n = ny_e[HEIGHT_COUNTER_SIZE:0];
                        end
                    end else begin
                        if (by_e < BALL_STEP_Y) begin
                            by_n = '0;
                            dy_n = 1'b1;
                        end else begin
                            by_n = ny_e[HEIGHT_COUNTER_SIZE:0];
                        end
                    end

                    if (hit_1) begin
                        bx_n = P1_STOP_X;
                        dx_n = 1'b1;
                    end else if (hit_2) begin
                        bx_n = P2_STOP_X;
                        dx_n = 1'b0;
                    end else begin
                        bx_n = nx_e[WIDTH_COUNTER_SIZE:0];
                    end

                    // A point overrides this frame's motion, including any Y bounce.
                    if (point_1 || point_2) begin
                        bx_n   = BALL_HOME_X;
                        by_n   = BALL_HOME_Y;
                        dx_n   = point_1;
                        dy_n   = 1'b1;
                        hold_n = '0;
                        if (point_1) s1_n = s1_q + 1'b1;
                        else         s2_n = s2_q + 1'b1;
                        if ((s1_n == SCORE_WIN) || (s2_n == SCORE_WIN)) state_n = S_GAME_OVER;
                        else                                            state_n = S_SCORED;
                    end
                end
            end

            S_SCORED: begin
                if (frame_tick) begin
                    p1_n   = paddle_step(p1_q, p1_up, p1_down);
                    p2_n   = paddle_step(p2_q, p2_up, p2_down);
                    hold_n = hold_q + 1'b1;
                    if (hold_n == HOLD_LAST) state_n = S_PLAY;
                end
            end

            S_GAME_OVER: begin
                if (serve_edge) begin
                    s1_n    = '0;
                    s2_n    = '0;
                    bx_n    = BALL_HOME_X;
                    by_n    = BALL_HOME_Y;
                    p1_n    = PADDLE_HOME;
                    p2_n    = PADDLE_HOME;
                    dx_n    = 1'b1;
                    dy_n    = 1'b1;
                    hold_n  = '0;
                    state_n = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign paddle_1_pos = p1_q;
    assign paddle_2_pos = p2_q;
    assign ball_pos_x   = bx_q;
    assign ball_pos_y   = by_q;
    assign score_1      = s1_q;
    assign score_2      = s2_q;
    assign game_state   = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller: reset, paddles, bounces, scoring,
// point hold, game over and restart, with hand-computed expected positions.
module tb_pong_game_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic       serve;
    logic [9:0] paddle_1_pos, paddle_2_pos, ball_pos_x, ball_pos_y;
    logic [3:0] score_1, score_2;
    logic [1:0] game_state;

    int checks   = 0;
    int failures = 0;
    int cnt;

    pong_game_controller dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .p1_up        (p1_up),
        .p1_down      (p1_down),
        .p2_up        (p2_up),
        .p2_down      (p2_down),
        .serve        (serve),
        .paddle_1_pos (paddle_1_pos),
        .paddle_2_pos (paddle_2_pos),
        .ball_pos_x   (ball_pos_x),
        .ball_pos_y   (ball_pos_y),
        .score_1      (score_1),
        .score_2      (score_2),
        .game_state   (game_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(ball_pos_x), x);
        check({tag, "_y"}, int'(ball_pos_y), y);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; serve = 1'b0;
        p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p1", int'(paddle_1_pos), 208);
        check("rst_p2", int'(paddle_2_pos), 208);
        check_ball("rst_ball", 316, 236);
        check("rst_s1", int'(score_1), 0);
        check("rst_s2", int'(score_2), 0);
        check("rst_state", int'(game_state), 0);
        @(negedge clk) rst = 1'b1;

        // Idle: ball must stay home without a serve
        for (int i = 1; i <= 200; i++) do_tick();
        check_ball("idle_ball", 316, 236);
        check("idle_state", int'(game_state), 0);

        // Paddle saturation
        p1_up = 1'b1; p2_down = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            do_tick();
            if (i == 51) begin
                check("sat_p1_t51", int'(paddle_1_pos), 4);
                check("sat_p2_t51", int'(paddle_2_pos), 412);
            end
            if (i == 52) begin
                check("sat_p1_t52", int'(paddle_1_pos), 0);
                check("sat_p2_t52", int'(paddle_2_pos), 416);
            end
        end
        check("sat_p1_t60", int'(paddle_1_pos), 0);
        check("sat_p2_t60", int'(paddle_2_pos), 416);
        p1_down = 1'b1; p2_up = 1'b1;
        for (int i = 1; i <= 5; i++) do_tick();
        check("both_p1", int'(paddle_1_pos), 0);
        check("both_p2", int'(paddle_2_pos), 416);
        p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;

        // Wall bounces, paddle 2 hit, paddle 1 hit
        pulse_serve();
        check("serve_state", int'(game_state), 1);
        check_ball("serve_ball", 316, 236);
        p2_down = 1'b1;
        for (int n = 1; n <= 439; n++) begin
            if (n == 53)  p2_down = 1'b0;
            if (n == 148) p1_down = 1'b1;
            if (n == 188) p1_down = 1'b0;
            do_tick();
            if (n == 1)   check_ball("mv_t1", 318, 238);
            if (n == 118) check_ball("wall_t118", 552, 472);
            if (n == 119) check_ball("wall_t119", 554, 470);
            if (n == 146) begin
                check_ball("hit2_t146", 608, 416);
                check("hit2_p2", int'(paddle_2_pos), 416);
            end
            if (n == 147) check_ball("hit2_t147", 606, 414);
            if (n == 200) check("p1_moved", int'(paddle_1_pos), 160);
            if (n == 354) check_ball("top_t354", 192, 0);
            if (n == 355) check_ball("top_t355", 190, 0);
            if (n == 356) check_ball("top_t356", 188, 2);
            if (n == 438) check_ball("hit1_t438", 24, 166);
            if (n == 439) check_ball("hit1_t439", 26, 168);
        end
        check("hit_state", int'(game_state), 1);
        check("hit_s1", int'(score_1), 0);

        // Asynchronous reset mid-play
        @(negedge clk) rst = 1'b0;
        #1;
        check("arst_state", int'(game_state), 0);
        check_ball("arst_ball", 316, 236);
        check("arst_p1", int'(paddle_1_pos), 208);
        check("arst_p2", int'(paddle_2_pos), 208);
        @(negedge clk) rst = 1'b1;

        // Miss on the right, point to player 1, then the hold
        pulse_serve();
        for (int n = 1; n <= 159; n++) begin
            do_tick();
            if (n == 158) begin
                check("miss_t158_x", int'(ball_pos_x), 632);
                check("miss_t158_s1", int'(score_1), 0);
            end
        end
        check("miss_s1", int'(score_1), 1);
        check("miss_state", int'(game_state), 2);
        check_ball("miss_ball", 316, 236);
        for (int i = 1; i <= 60; i++) begin
            do_tick();
            if (i == 30) begin
                pulse_serve();
                check("hold_serve_ign", int'(game_state), 2);
            end
            if (i == 59) begin
                check("hold_t59_state", int'(game_state), 2);
                check_ball("hold_t59", 316, 236);
            end
        end
        check("hold_done_state", int'(game_state), 1);
        check_ball("hold_done", 316, 236);
        do_tick();
        check_ball("resume", 318, 238);
        pulse_serve();
        check("play_serve_ign", int'(game_state), 1);
        check("play_serve_x", int'(ball_pos_x), 318);

        // Run to game over
        cnt = 0;
        while (game_state != 2'd3 && cnt < 2500) begin
            do_tick();
            cnt++;
        end
        check("go_ticks", cnt, 1691);
        check("go_state", int'(game_state), 3);
        check("go_s1", int'(score_1), 9);
        check("go_s2", int'(score_2), 0);
        check_ball("go_ball", 316, 236);
        p1_up = 1'b1; p2_down = 1'b1;
        for (int i = 1; i <= 5; i++) do_tick();
        check("frz_p1", int'(paddle_1_pos), 208);
        check("frz_p2", int'(paddle_2_pos), 208);
        check("frz_state", int'(game_state), 3);
        check("frz_s1", int'(score_1), 9);
        p1_up = 1'b0; p2_down = 1'b0;

        // Restart with serve held high: exactly one edge
        @(negedge clk) serve = 1'b1;
        @(negedge clk);
        check("rs_state", int'(game_state), 0);
        check("rs_s1", int'(score_1), 0);
        for (int i = 1; i <= 3; i++) do_tick();
        check("rs_held_state", int'(game_state), 0);
        check_ball("rs_ball", 316, 236);
        @(negedge clk) serve = 1'b0;

        // Return off paddle 2, miss on the left, point to player 2
        pulse_serve();
        check("p2run_state", int'(game_state), 1);
        p2_down = 1'b1;
        for (int n = 1; n <= 451; n++) begin
            if (n == 53) p2_down = 1'b0;
            do_tick();
            if (n == 146) check("p2run_t146_x", int'(ball_pos_x), 608);
            if (n == 450) begin
                check("p2run_t450_x", int'(ball_pos_x), 0);
                check("p2run_t450_s2", int'(score_2), 0);
            end
        end
        check("pt2_s2", int'(score_2), 1);
        check("pt2_s1", int'(score_1), 0);
        check("pt2_state", int'(game_state), 2);
        check_ball("pt2_ball", 316, 236);
        for (int i = 1; i <= 60; i++) do_tick();
        check("pt2_play", int'(game_state), 1);
        do_tick();
        check_ball("pt2_resume", 314, 238);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
